// File: rtl/uart_pkg.sv
// Shared UART definitions: parser state encoding, default start-of-frame marker
// and the bit-period computation also used by the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        LEN,
        PAYLOAD,
        CHK,
        HOLD
    } parser_state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_pl_buf.sv
// Payload buffer: one write port from the parser, one registered read port.
// Contents are deliberately not reset; only the read register is.
module uart_pl_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// Turns the UART receiver byte stream into checked command frames
// (SOF, CMD, LEN, payload, XOR checksum) offered through a valid/ready handshake.
module uart_cmd_parser
    import uart_pkg::*;
#(
    parameter int          CLOCK_FREQ    = 50000000,
    parameter int          BAUD_RATE     = 9600,
    parameter int          MAX_PAYLOAD   = 16,
    parameter logic [7:0]  SOF_BYTE      = SOF_DEFAULT,
    parameter int          TIMEOUT_BYTES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_valid,
    output logic                           frame_valid,
    input  logic                           frame_ready,
    output logic [7:0]                     frame_cmd,
    output logic [7:0]                     frame_len,
    input  logic [$clog2(MAX_PAYLOAD)-1:0] pl_rd_addr,
    output logic [7:0]                     pl_rd_data,
    output logic                           err_chk,
    output logic                           err_len,
    output logic                           err_timeout,
    output logic                           overrun
);

    localparam int              AW           = $clog2(MAX_PAYLOAD);
    localparam int              TIMEOUT_CLKS = TIMEOUT_BYTES * 10 * clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int              TW           = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0]   TMO_LAST     = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]      MAX_LEN      = 8'(MAX_PAYLOAD);

    parser_state_t state_q, state_d;
    logic [7:0]    xor_q, xor_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    cur_cmd_q, cur_cmd_d;
    logic [7:0]    cur_len_q, cur_len_d;
    logic          frame_valid_q, frame_valid_d;
    logic [7:0]    frame_cmd_q, frame_cmd_d;
    logic [7:0]    frame_len_q, frame_len_d;
    logic          err_chk_q, err_chk_d;
    logic          err_len_q, err_len_d;
    logic          err_timeout_q, err_timeout_d;
    logic          overrun_q, overrun_d;

    logic          buf_we;
    logic          tmo_active;
    logic          tmo_expire;
    logic          is_sof;

    assign tmo_active = (state_q == CMD) || (state_q == LEN) ||
                        (state_q == PAYLOAD) || (state_q == CHK);
    // An arriving byte always beats the terminal count.
    assign tmo_expire = tmo_active && !rx_valid && (tmo_q == TMO_LAST);
    assign is_sof     = rx_valid && (rx_data == SOF_BYTE);

    always_comb begin
        state_d       = state_q;
        xor_d         = xor_q;
        tmo_d         = '0;
        idx_d         = idx_q;
        cur_cmd_d     = cur_cmd_q;
        cur_len_d     = cur_len_q;
        frame_valid_d = frame_valid_q;
        frame_cmd_d   = frame_cmd_q;
        frame_len_d   = frame_len_q;
        err_chk_d     = 1'b0;
        err_len_d     = 1'b0;
        err_timeout_d = 1'b0;
        overrun_d     = 1'b0;
        buf_we        = 1'b0;

        if (tmo_active && !rx_valid && !tmo_expire) begin
            tmo_d = tmo_q + 1'b1;
        end

        if (tmo_expire) begin
            err_timeout_d = 1'b1;
            state_d       = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_sof) begin
                        xor_d   = 8'h00;
                        state_d = CMD;
                    end
                end
                CMD: begin
                    if (rx_valid) begin
                        cur_cmd_d = rx_data;
                        xor_d     = xor_q ^ rx_data;
                        state_d   = LEN;
                    end
                end
                LEN: begin
                    if (rx_valid) begin
                        cur_len_d = rx_data;
                        xor_d     = xor_q ^ rx_data;
                        idx_d     = 8'h00;
                        if (rx_data > MAX_LEN) begin
                            err_len_d = 1'b1;
                            state_d   = IDLE;
                        end else if (rx_data == 8'h00) begin
                            state_d = CHK;
                        end else begin
                            state_d = PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (rx_valid) begin
                        buf_we = 1'b1;
                        xor_d  = xor_q ^ rx_data;
                        idx_d  = idx_q + 8'd1;
                        if (idx_q == cur_len_q - 8'd1) begin
                            state_d = CHK;
                        end
                    end
                end
                CHK: begin
                    if (rx_valid) begin
                        if (rx_data == xor_q) begin
                            frame_valid_d = 1'b1;
                            frame_cmd_d   = cur_cmd_q;
                            frame_len_d   = cur_len_q;
                            state_d       = HOLD;
                        end else begin
                            err_chk_d = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                end
                HOLD: begin
                    // Releasing the frame lets the same cycle's byte be judged as in IDLE.
                    if (frame_ready) begin
                        frame_valid_d = 1'b0;
                        state_d       = IDLE;
                        if (is_sof) begin
                            xor_d   = 8'h00;
                            state_d = CMD;
                        end
                    end else if (rx_valid) begin
                        overrun_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            xor_q         <= 8'h00;
            tmo_q         <= '0;
            idx_q         <= 8'h00;
            cur_cmd_q     <= 8'h00;
            cur_len_q     <= 8'h00;
            frame_valid_q <= 1'b0;
            frame_cmd_q   <= 8'h00;
            frame_len_q   <= 8'h00;
            err_chk_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            xor_q         <= xor_d;
            tmo_q         <= tmo_d;
            idx_q         <= idx_d;
            cur_cmd_q     <= cur_cmd_d;
            cur_len_q     <= cur_len_d;
            frame_valid_q <= frame_valid_d;
            frame_cmd_q   <= frame_cmd_d;
            frame_len_q   <= frame_len_d;
            err_chk_q     <= err_chk_d;
            err_len_q     <= err_len_d;
            err_timeout_q <= err_timeout_d;
            overrun_q     <= overrun_d;
        end
    end

    uart_pl_buf #(
        .DEPTH (MAX_PAYLOAD),
        .AW    (AW)
    ) u_pl_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (buf_we),
        .waddr (idx_q[AW-1:0]),
        .wdata (rx_data),
        .raddr (pl_rd_addr),
        .rdata (pl_rd_data)
    );

    assign frame_valid = frame_valid_q;
    assign frame_cmd   = frame_cmd_q;
    assign frame_len   = frame_len_q;
    assign err_chk     = err_chk_q;
    assign err_len     = err_len_q;
    assign err_timeout = err_timeout_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: good, corrupt, oversize, stalled, overrun
// and reset-aborted frames, with a shortened timeout for simulation speed.
module tb_uart_cmd_parser;

    localparam int CLOCK_FREQ    = 1000;
    localparam int BAUD_RATE     = 100;
    localparam int MAX_PAYLOAD   = 16;
    localparam int TIMEOUT_BYTES = 2;
    localparam int T_CLKS        = TIMEOUT_BYTES * 10 * (CLOCK_FREQ / BAUD_RATE);

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_valid;
    logic       frame_ready;
    logic [7:0] frame_cmd;
    logic [7:0] frame_len;
    logic [3:0] pl_rd_addr;
    logic [7:0] pl_rd_data;
    logic       err_chk;
    logic       err_len;
    logic       err_timeout;
    logic       overrun;

    int vectors     = 0;
    int miscompares = 0;
    int n_chk = 0, n_len = 0, n_tmo = 0, n_ovr = 0;

    uart_cmd_parser #(
        .CLOCK_FREQ    (CLOCK_FREQ),
        .BAUD_RATE     (BAUD_RATE),
        .MAX_PAYLOAD   (MAX_PAYLOAD),
        .SOF_BYTE      (8'hA5),
        .TIMEOUT_BYTES (TIMEOUT_BYTES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_cmd   (frame_cmd),
        .frame_len   (frame_len),
        .pl_rd_addr  (pl_rd_addr),
        .pl_rd_data  (pl_rd_data),
        .err_chk     (err_chk),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Each pulse is one cycle wide, so exactly one falling edge sees it.
    always @(negedge clk) begin
        if (rst_n) begin
            n_chk += int'(err_chk);
            n_len += int'(err_len);
            n_tmo += int'(err_timeout);
            n_ovr += int'(overrun);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic release_frame();
        @(negedge clk);
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
    endtask

    task automatic read_pl(input logic [3:0] addr, output logic [7:0] data);
        pl_rd_addr = addr;
        @(negedge clk);
        data = pl_rd_data;
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] chk16;
        int         c0, pulse_at;

        rst_n       = 1'b0;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        frame_ready = 1'b0;
        pl_rd_addr  = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        check("rst_frame_cmd", 32'(frame_cmd), 32'h00);
        check("rst_frame_len", 32'(frame_len), 32'h00);
        check("rst_pl_rd_data", 32'(pl_rd_data), 32'h00);
        check("rst_errors", {28'd0, err_chk, err_len, err_timeout, overrun}, 32'd0);
        rst_n = 1'b1;

        // Good frame A5 10 02 11 22 21
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22);
        check("a_valid_before_chk", 32'(frame_valid), 32'd0);
        send_byte(8'h21);
        $display("frame A5 10 02 11 22 21 sent");
        check("a_valid", 32'(frame_valid), 32'd1);
        check("a_cmd", 32'(frame_cmd), 32'h10);
        check("a_len", 32'(frame_len), 32'h02);
        read_pl(4'd0, rd); check("a_pl0", 32'(rd), 32'h11);
        read_pl(4'd1, rd); check("a_pl1", 32'(rd), 32'h22);
        repeat (5) @(negedge clk);
        check("a_valid_held", 32'(frame_valid), 32'd1);
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        check("a_valid_fall", 32'(frame_valid), 32'd0);

        // Same frame, bad checksum
        c0 = n_chk;
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h00);
        $display("frame A5 10 02 11 22 00 sent");
        check("b_err_chk_pulse", 32'(err_chk), 32'd1);
        check("b_valid", 32'(frame_valid), 32'd0);
        repeat (3) @(negedge clk);
        check("b_err_chk_once", 32'(n_chk - c0), 32'd1);
        send_byte(8'hA5); send_byte(8'h33); send_byte(8'h01);
        send_byte(8'h44); send_byte(8'h76);
        $display("frame A5 33 01 44 76 sent");
        check("b2_valid", 32'(frame_valid), 32'd1);
        check("b2_cmd", 32'(frame_cmd), 32'h33);
        read_pl(4'd0, rd); check("b2_pl0", 32'(rd), 32'h44);
        release_frame();

        // LEN above MAX_PAYLOAD, then junk bytes
        c0 = n_chk + n_len + n_tmo + n_ovr;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'hFF);
        $display("frame A5 01 FF sent");
        check("c_err_len", 32'(err_len), 32'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        repeat (2) @(negedge clk);
        check("c_errs_total", 32'(n_chk + n_len + n_tmo + n_ovr - c0), 32'd1);
        check("c_valid", 32'(frame_valid), 32'd0);

        // LEN exactly MAX_PAYLOAD is accepted
        chk16 = 8'h5C ^ 8'd16;
        send_byte(8'hA5); send_byte(8'h5C); send_byte(8'd16);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h80 + 8'(i));
            chk16 = chk16 ^ (8'h80 + 8'(i));
        end
        send_byte(chk16);
        $display("frame A5 5C 10 80..8F %h sent", chk16);
        check("d_valid", 32'(frame_valid), 32'd1);
        check("d_len", 32'(frame_len), 32'd16);
        read_pl(4'd15, rd); check("d_pl15", 32'(rd), 32'h8F);
        release_frame();

        // Stall after CMD: timeout
        c0 = n_tmo;
        pulse_at = -1;
        send_byte(8'hA5); send_byte(8'h07);
        $display("frame A5 07 sent, then silence");
        for (int i = 1; i <= T_CLKS + 10; i++) begin
            @(negedge clk);
            if (err_timeout && pulse_at < 0) pulse_at = i;
        end
        check("e_tmo_cycle", 32'(pulse_at), 32'(T_CLKS));
        check("e_tmo_once", 32'(n_tmo - c0), 32'd1);
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h07);
        $display("frame A5 07 00 07 sent");
        check("e_zero_valid", 32'(frame_valid), 32'd1);
        check("e_zero_len", 32'(frame_len), 32'd0);
        check("e_zero_cmd", 32'(frame_cmd), 32'h07);
        release_frame();

        // Overrun while held, then SOF in the release cycle
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h21);
        c0 = n_ovr;
        send_byte(8'h55);
        $display("byte 55 sent while frame held");
        check("f_overrun", 32'(overrun), 32'd1);
        check("f_valid_kept", 32'(frame_valid), 32'd1);
        check("f_cmd_kept", 32'(frame_cmd), 32'h10);
        @(negedge clk);
        check("f_overrun_once", 32'(n_ovr - c0), 32'd1);
        rx_data     = 8'hA5;
        rx_valid    = 1'b1;
        frame_ready = 1'b1;
        @(negedge clk);
        rx_valid    = 1'b0;
        frame_ready = 1'b0;
        check("f_released", 32'(frame_valid), 32'd0);
        send_byte(8'h20); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h7B);
        $display("frame (A5) 20 01 5A 7B sent");
        check("f2_valid", 32'(frame_valid), 32'd1);
        check("f2_cmd", 32'(frame_cmd), 32'h20);
        read_pl(4'd0, rd); check("f2_pl0", 32'(rd), 32'h5A);
        release_frame();

        // Reset in PAYLOAD
        pl_rd_addr = 4'd0;
        send_byte(8'hA5); send_byte(8'h44); send_byte(8'h03); send_byte(8'h01);
        #2 rst_n = 1'b0;
        #1;
        $display("reset asserted during payload");
        check("g_rst_cmd", 32'(frame_cmd), 32'h00);
        check("g_rst_rd", 32'(pl_rd_data), 32'h00);
        check("g_rst_valid", 32'(frame_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'hA5); send_byte(8'h66); send_byte(8'h02);
        send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h02);
        $display("frame A5 66 02 AB CD 02 sent");
        check("g2_valid", 32'(frame_valid), 32'd1);
        check("g2_cmd", 32'(frame_cmd), 32'h66);
        read_pl(4'd1, rd); check("g2_pl1", 32'(rd), 32'hCD);
        release_frame();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
